t05_tree_node_builder: RTL
==========================

// Module: t05_tree_node_builder
// PURPOSE
// - Huffman tree-build stage directly downstream of the least-value finder.
// - Per round it takes the two smallest entries (least1, least2) and their sum, writes one
//   internal node {left, right, count} to the node table, then zeroes both consumed entries
//   so the finder skips them next scan.
// - Detects the final round (single survivor), latches the root index and signals done to the
//   top-level controller.
// PARAMETERS
// - MAX_NODES  255  internal-node capacity (node_cnt range 0..MAX_NODES-1)
// - CNT_W      64   count/sum width; matches finder sum/compVal
// - ST_ID      4'd3 en_state code in which this block is active
// - ST_FIN     4'd4 fin_state code driven when the tree is complete
// PORTS
// - clk          in   1        system clock
// - rst          in   1        synchronous, active-high reset
// - en_state     in   4        top-level state; block runs only while == ST_ID
// - in_valid     in   1        1-cycle pulse: least1/least2/sum valid
// - least1       in   9        smallest entry; [8]=1 internal node, [7:0] char/node index
// - least2       in   9        second smallest; 9'h1FF = NULL (no second entry)
// - sum          in   CNT_W    least1.count + least2.count
// - mem_wr_req   out  1        write request to shared hist/node memory
// - mem_wr_ack   in   1        1-cycle accept from arbiter
// - mem_wr_addr  out  9        [8]=0 histogram slot, [8]=1 node-table slot
// - mem_wr_data  out  82       {left[8:0], right[8:0], count[CNT_W-1:0]}
// - node_cnt     out  8        internal nodes written so far
// - root_idx     out  9        root entry, valid while tree_done
// - round_done   out  1        1-cycle pulse after node write + both wipes
// - tree_done    out  1        sticky completion flag
// - fin_state    out  4        ST_FIN while tree_done, else 4'd0
// - err          out  1        sticky error (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0, root_idx=9'h1FF, FSM=IDLE; any outstanding request is dropped.
//   Reset mid-round discards the round; node_cnt is not incremented.
// - en_state!=ST_ID: FSM forced to IDLE next cycle, req deasserted; node_cnt/tree_done/root_idx hold.
// - FSM states: IDLE -> NODE -> WIPE1 -> WIPE2 -> IDLE; IDLE -> DONE; IDLE/any -> ERR (macro).
// - IDLE + in_valid + least2!=NULL: latch inputs, go to NODE. in_valid outside IDLE is ignored.
// - IDLE + in_valid + least2==NULL: root_idx<=least1, tree_done<=1, go to DONE, no writes.
// - NODE: req=1, addr={1'b1,node_cnt}, data={least1,least2,sum}; on ack go to WIPE1.
// - WIPE1: addr=least1, data=0. On ack go to WIPE2.
// - WIPE2: addr=least2, data=0. On ack: round_done pulse, node_cnt+1, go to IDLE.
// - Handshake: addr/data stable while req=1. Ack counts only when req=1. Ack in the same cycle
//   req rises is legal. Next request is issued the cycle after ack. Min round = 3 cycles + 1 idle.
// - sum is stored unmodified (no saturation).
// - DONE: holds until rst. fin_state=ST_FIN.
// CONFIGURATION
// - Macro T05_TREE_ERR_EN defined: ERR state entered (err=1, sticky, writes stop) on any of:
//   - in_valid with least1==NULL
//   - in_valid with least1==least2
//   - in_valid with node_cnt==MAX_NODES
// - Macro T05_TREE_ERR_EN undefined: no checks. err tied 0. Inputs are trusted.
// STRUCTURE
// - Package t05_tree_pkg:
//   - NULL_IDX=9'h1FF
//   - node_t packed struct {left,right,count}
//   - tree_state_t enum {IDLE,NODE,WIPE1,WIPE2,DONE,ERR}
//   - ST_* codes
// - Sub-module t05_mem_wr_port: req/ack holding register for addr/data. FSM loads it, gets
//   'accepted' back.
// TESTING
// - Reset then en_state=3, in_valid with least1=9'h041, least2=9'h042, sum=30, ack 1 cycle
//   after req -> writes {1'b1,8'h00}<-{041,042,30}, 041<-0, 042<-0. round_done, node_cnt=1.
// - Second round least1=9'h100, least2=9'h043, sum=70, ack delayed 5 cycles -> req/addr/data
//   held stable 5 cycles per write, node_cnt=2.
// - in_valid least1=9'h101, least2=9'h1FF -> no req, tree_done=1, root_idx=9'h101, fin_state=4.
// - rst pulsed while in WIPE1 -> req=0 next cycle, node_cnt unchanged, outputs at reset values.
// - en_state drops to 2 during NODE with no ack -> IDLE, req=0. in_valid while en_state!=3 ignored.
// - With T05_TREE_ERR_EN: least1=least2=9'h050 -> err=1, no writes. Without the macro: round
//   executes normally, err=0.

Source files
------------

// File: rtl/t05_tree_pkg.sv
// Shared types and constants for the Huffman tree node builder.
// Holds the NULL entry code, node record layout, FSM states and top-level state codes.
package t05_tree_pkg;

   localparam logic [8:0] NULL_IDX      = 9'h1FF;
   localparam int         NODE_CNT_W    = 64;
   localparam logic [3:0] ST_TREE_BUILD = 4'd3;
   localparam logic [3:0] ST_TREE_FIN   = 4'd4;

   typedef struct packed {
      logic [8:0]            left;
      logic [8:0]            right;
      logic [NODE_CNT_W-1:0] count;
   } node_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      NODE  = 3'd1,
      WIPE1 = 3'd2,
      WIPE2 = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } tree_state_t;

endpackage

// File: rtl/t05_mem_wr_port.sv
// Request/acknowledge holding register for the shared hist/node memory write port.
// Ports: i_load captures i_addr/i_data and raises o_req; o_accepted = o_req & i_ack;
// i_flush (or rst) drops any outstanding request.
module t05_mem_wr_port
   import t05_tree_pkg::*;
#(
   parameter int DW = 82
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_flush,
   input  logic          i_load,
   input  logic [8:0]    i_addr,
   input  logic [DW-1:0] i_data,
   input  logic          i_ack,
   output logic          o_req,
   output logic [8:0]    o_addr,
   output logic [DW-1:0] o_data,
   output logic          o_accepted
);

   logic          r_req;
   logic [8:0]    r_addr;
   logic [DW-1:0] r_data;

   assign o_accepted = r_req & i_ack;
   assign o_req      = r_req;
   assign o_addr     = r_addr;
   assign o_data     = r_data;

   // A load in the accept cycle chains straight into the next
   // request, so back-to-back writes keep req high.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_req  <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else if (i_load) begin
         r_req  <= 1'b1;
         r_addr <= i_addr;
         r_data <= i_data;
      end else if (o_accepted) begin
         r_req  <= 1'b0;
      end
   end

endmodule

// File: rtl/t05_tree_node_builder.sv
// Huffman tree-build stage: writes one internal node per round, wipes both consumed
// entries, and latches the root when a single survivor is presented.
// Ports: clk/rst; en_state gates activity; in_valid/least1/least2/sum from the finder;
// mem_wr_req/ack/addr/data to the arbiter; node_cnt, root_idx, round_done, tree_done,
// fin_state, err status. Macro T05_TREE_ERR_EN enables input sanity checks (ERR state).
module t05_tree_node_builder
   import t05_tree_pkg::*;
#(
   parameter int         MAX_NODES = 255,
   parameter int         CNT_W     = 64,
   parameter logic [3:0] ST_ID     = ST_TREE_BUILD,
   parameter logic [3:0] ST_FIN    = ST_TREE_FIN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       en_state,
   input  logic             in_valid,
   input  logic [8:0]       least1,
   input  logic [8:0]       least2,
   input  logic [CNT_W-1:0] sum,
   output logic             mem_wr_req,
   input  logic             mem_wr_ack,
   output logic [8:0]       mem_wr_addr,
   output logic [CNT_W+17:0] mem_wr_data,
   output logic [7:0]       node_cnt,
   output logic [8:0]       root_idx,
   output logic             round_done,
   output logic             tree_done,
   output logic [3:0]       fin_state,
   output logic             err
);

   tree_state_t      r_state;
   logic [8:0]       r_l1;
   logic [8:0]       r_l2;
   logic [7:0]       r_node_cnt;
   logic [8:0]       r_root;
   logic             r_done;
   logic             r_rdone;

   logic             w_active;
   logic             w_acc;
   logic             w_bad;
   logic             w_load;
   logic [8:0]       w_ld_addr;
   logic [CNT_W+17:0] w_ld_data;

   assign w_active = (en_state == ST_ID);

`ifdef T05_TREE_ERR_EN
   logic r_err;

   assign w_bad = (least1 == NULL_IDX) ||
                  (least1 == least2)   ||
                  (r_node_cnt == 8'(MAX_NODES));

   always_ff @(posedge clk) begin
      if (rst)
         r_err <= 1'b0;
      else if (w_active && r_state == IDLE && in_valid && w_bad)
         r_err <= 1'b1;
   end

   assign err = r_err;
`else
   assign w_bad = 1'b0;
   assign err   = 1'b0;
`endif

   // Next write is loaded in the same cycle the FSM moves,
   // so req is high in NODE, WIPE1 and WIPE2.
   always_comb begin
      w_load    = 1'b0;
      w_ld_addr = '0;
      w_ld_data = '0;
      if (w_active) begin
         case (r_state)
            IDLE: begin
               if (in_valid && !w_bad && least2 != NULL_IDX) begin
                  w_load    = 1'b1;
                  w_ld_addr = {1'b1, r_node_cnt};
                  w_ld_data = {least1, least2, sum};
               end
            end
            NODE: begin
               if (w_acc) begin
                  w_load    = 1'b1;
                  w_ld_addr = r_l1;
               end
            end
            WIPE1: begin
               if (w_acc) begin
                  w_load    = 1'b1;
                  w_ld_addr = r_l2;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_l1       <= '0;
         r_l2       <= '0;
         r_node_cnt <= '0;
         r_root     <= NULL_IDX;
         r_done     <= 1'b0;
         r_rdone    <= 1'b0;
      end else begin
         r_rdone <= 1'b0;
         if (!w_active) begin
            // Terminal states survive a state-code change.
            if (r_state != DONE && r_state != ERR)
               r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (in_valid) begin
                     if (w_bad) begin
                        r_state <= ERR;
                     end else if (least2 == NULL_IDX) begin
                        r_root  <= least1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                     end else begin
                        r_l1    <= least1;
                        r_l2    <= least2;
                        r_state <= NODE;
                     end
                  end
               end
               NODE: if (w_acc) r_state <= WIPE1;
               WIPE1: if (w_acc) r_state <= WIPE2;
               WIPE2: begin
                  if (w_acc) begin
                     r_rdone <= 1'b1;
                     if (r_node_cnt != 8'(MAX_NODES))
                        r_node_cnt <= r_node_cnt + 8'd1;
                     r_state <= IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   t05_mem_wr_port #(
      .DW (CNT_W + 18)
   ) u_wr_port (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (~w_active),
      .i_load     (w_load),
      .i_addr     (w_ld_addr),
      .i_data     (w_ld_data),
      .i_ack      (mem_wr_ack),
      .o_req      (mem_wr_req),
      .o_addr     (mem_wr_addr),
      .o_data     (mem_wr_data),
      .o_accepted (w_acc)
   );

   assign node_cnt   = r_node_cnt;
   assign root_idx   = r_root;
   assign round_done = r_rdone;
   assign tree_done  = r_done;
   assign fin_state  = r_done ? ST_FIN : 4'd0;

endmodule
